// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Registered ripple-borrow subtractor; diff/bor_out = a - b - bor_in
//               from a chain of 1-bit full-subtractor cells, one cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bor_in,
    output logic [WIDTH-1:0] diff,
    output logic             bor_out
);

    // w_br[i] is the borrow into cell i; w_br[WIDTH] leaves the MSB
    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] r_diff;
    logic             r_bor_out;

    assign w_br[0] = bor_in;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            logic w_axb;
            assign w_axb       = a[i] ^ b[i];
            assign w_diff[i]   = w_axb ^ w_br[i];
            assign w_br[i + 1] = (~a[i] & b[i]) | (~w_axb & w_br[i]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff    <= '0;
            r_bor_out <= 1'b0;
        end else begin
            r_diff    <= w_diff;
            r_bor_out <= w_br[WIDTH];
        end
    end

    assign diff    = r_diff;
    assign bor_out = r_bor_out;

endmodule
`default_nettype wire

// File: tb/tb_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_subtractor
// Description : Scoreboard bench for full_subtractor at WIDTH=1 and WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, c1;
    logic [3:0] a4, b4;
    logic       c4;
    logic       d1, bo1;
    logic [3:0] d4;
    logic       bo4;

    int n_checks = 0;
    int n_fails  = 0;

    logic [1:0] q1 [$];   // {bor_out, diff}
    logic [4:0] q4 [$];   // {bor_out, diff}

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .bor_in(c1),
        .diff(d1), .bor_out(bo1)
    );

    full_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .bor_in(c4),
        .diff(d4), .bor_out(bo4)
    );

    // Apply one cycle of stimulus just after an edge and record what the
    // next edge must produce.
    task automatic step(input logic r,
                        input logic v1, input logic ia1, input logic ib1,
                        input logic ic1, input logic [1:0] e1,
                        input logic v4, input logic [3:0] ia4,
                        input logic [3:0] ib4, input logic ic4,
                        input logic [4:0] e4);
        @(posedge clk);
        #1;
        rst = r;
        a1 = ia1; b1 = ib1; c1 = ic1;
        a4 = ia4; b4 = ib4; c4 = ic4;
        if (v1) q1.push_back(e1);
        if (v4) q4.push_back(e4);
    endtask

    // Monitor: an entry queued before an edge is due at the following negedge,
    // by which time the driver has already moved the inputs on.
    initial begin
        forever begin
            logic h1, h4;
            logic [1:0] x1;
            logic [4:0] x4;
            @(posedge clk);
            h1 = (q1.size() > 0);
            h4 = (q4.size() > 0);
            @(negedge clk);
            if (h1) begin
                x1 = q1.pop_front();
                n_checks++;
                if ({bo1, d1} !== x1) begin
                    n_fails++;
                    $display("FAIL w1_result: got bor=%b diff=%b, expected bor=%b diff=%b",
                             bo1, d1, x1[1], x1[0]);
                end
            end
            if (h4) begin
                x4 = q4.pop_front();
                n_checks++;
                if ({bo4, d4} !== x4) begin
                    n_fails++;
                    $display("FAIL w4_result: got bor=%b diff=%h, expected bor=%b diff=%h",
                             bo4, d4, x4[4], x4[3:0]);
                end
            end
        end
    end

    // WIDTH=1 truth table, indexed by {a,b,bor_in}: {bor_out, diff}
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    // WIDTH=4 back-to-back stream: a, b, bor_in, expected {bor_out, diff}
    logic [3:0] sa [16] = '{4'd3, 4'd1, 4'd7, 4'd7, 4'd8, 4'd0, 4'd15, 4'd10,
                            4'd12, 4'd2, 4'd6, 4'd4, 4'd13, 4'd1, 4'd0, 4'd11};
    logic [3:0] sb [16] = '{4'd1, 4'd3, 4'd7, 4'd7, 4'd1, 4'd15, 4'd15, 4'd4,
                            4'd5, 4'd9, 4'd2, 4'd4, 4'd6, 4'd0, 4'd0, 4'd3};
    logic       sc [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                            1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] se [16] = '{5'h02, 5'h1E, 5'h00, 5'h1F, 5'h06, 5'h10, 5'h1F, 5'h06,
                            5'h06, 5'h19, 5'h03, 5'h1F, 5'h07, 5'h00, 5'h1F, 5'h08};

    initial begin
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
        repeat (2) @(posedge clk);

        // Reset holds outputs at zero with a=1 applied, then releases
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'd1, 4'd0, 1'b0, 5'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'd1, 4'd0, 1'b0, 5'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'd1, 4'd0, 1'b0, 5'h01);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step(1'b0, 1'b1, v[2], v[1], v[0], tt[i], 1'b0, 4'd0, 4'd0, 1'b0, 5'h00);
        end

        // Underflow and no-borrow corners
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0,  4'd1, 1'b0, 5'h1F);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd5,  4'd5, 1'b1, 5'h1F);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd9,  4'd3, 1'b1, 5'h05);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd15, 4'd0, 1'b0, 5'h0F);

        // Stream with a one-cycle reset in the middle
        for (int i = 0; i < 16; i++) begin
            logic r;
            r = (i == 8);
            step(r, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                 1'b1, sa[i], sb[i], sc[i], r ? 5'h00 : se[i]);
        end

        repeat (4) @(posedge clk);
        n_checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d/%0d pending results, expected 0/0",
                     q1.size(), q4.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
